lfsr_decrypter_multi: RTL and testbench

- Parametrised successor to the fixed 6-LFSR, 5-bit, 64-byte decrypter.
- Takes a start pulse and reads an encrypted message from data memory at SRC_BASE. Seeds N_TAPS candidate Fibonacci LFSRs from the first character XOR the known preamble character.
- Eliminates candidates over the preamble training window, selects the surviving tap pattern, then decrypts the message body into memory at DST_BASE.
- Sits between the testbench/memory mux and dat_mem in place of the hard-coded cycle-count sequencer.

---
 rtl/lfsr_decrypter_multi_if.sv | 28 ++
 rtl/lfsr_decrypter_multi.sv | 194 +++++++++++++++++++
 tb/tb_lfsr_decrypter_multi.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_decrypter_multi_if.sv
// Memory-side bus of the multi-tap LFSR decrypter.
// Master is the decrypter; slave is the data memory (rdata lags raddr by one cycle).
interface lfsr_decrypter_multi_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;
    logic              wr_en;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    modport master (
        output raddr,
        input  rdata,
        output wr_en,
        output waddr,
        output wdata
    );

    modport slave (
        input  raddr,
        output rdata,
        input  wr_en,
        input  waddr,
        input  wdata
    );
endinterface

// File: rtl/lfsr_decrypter_multi.sv
// Multi-candidate LFSR decrypter: trains N_TAPS Fibonacci LFSRs on a known
// preamble, keeps the surviving tap pattern and decrypts the message body.
module lfsr_decrypter_multi #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int LFSR_W = 5,
    parameter int N_TAPS = 6,
    parameter logic [N_TAPS*LFSR_W-1:0] TAP_TABLE =
        {5'h12, 5'h14, 5'h17, 5'h1B, 5'h1D, 5'h1E},
    parameter int MSG_LEN  = 64,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] preamble,
    input  logic [ADDR_W-1:0] pre_len,
    input  logic              keep_pre,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              ambiguous,
    output logic [3:0]        found_idx,
    lfsr_decrypter_multi_if.master mem
);
    localparam int CNT_W = ADDR_W + 1;
    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [LFSR_W-1:0] lfsr_t;
    localparam cnt_t              C_LEN = cnt_t'(MSG_LEN);
    localparam logic [ADDR_W-1:0] C_SRC = ADDR_W'(SRC_BASE);
    localparam logic [ADDR_W-1:0] C_DST = ADDR_W'(DST_BASE);

    typedef enum logic [2:0] {
        S_IDLE, S_SEED, S_TRAIN, S_RESOLVE, S_DECRYPT, S_FIN
    } state_t;

    state_t            r_state, w_state_nxt;
    cnt_t              r_k, r_p, w_p;
    logic              r_keep;
    logic [N_TAPS-1:0] r_mask, w_hit;
    lfsr_t             r_seed, w_seed, w_key;
    lfsr_t             r_lfsr [N_TAPS];
    lfsr_t             w_step [N_TAPS];
    logic [ADDR_W-1:0] r_waddr, w_raddr, w_k_addr;
    logic              r_done, r_error, r_amb;
    logic [3:0]        r_idx, w_low;
    logic [4:0]        w_cnt;
    logic [DATA_W-1:0] w_dec;
    logic              w_wr;

    assign w_seed   = mem.rdata[LFSR_W-1:0] ^ preamble[LFSR_W-1:0];
    assign w_k_addr = C_SRC + r_k[ADDR_W-1:0] + ADDR_W'(1);
    assign w_dec    = mem.rdata ^ DATA_W'(w_key);
    assign w_wr     = (r_state == S_DECRYPT) && (r_keep || (r_k >= r_p));

    assign mem.raddr = w_raddr;
    assign mem.wr_en = w_wr & rst_n;
    assign mem.waddr = r_waddr;
    assign mem.wdata = w_dec;

    assign busy      = (r_state == S_SEED) || (r_state == S_TRAIN) ||
                       (r_state == S_RESOLVE) || (r_state == S_DECRYPT);
    assign done      = r_done;
    assign error     = r_error;
    assign ambiguous = r_amb;
    assign found_idx = r_idx;

    // Clamp the requested training window to 1..MSG_LEN
    always_comb begin
        w_p = cnt_t'(pre_len);
        if (w_p > C_LEN) w_p = C_LEN;
        if (w_p == '0) w_p = cnt_t'(1);
    end

    // Step every candidate and test its plaintext guess against the preamble
    always_comb begin
        for (int i = 0; i < N_TAPS; i++) begin
            w_step[i] = {r_lfsr[i][LFSR_W-2:0],
                         ^(r_lfsr[i] & TAP_TABLE[i*LFSR_W +: LFSR_W])};
            w_hit[i]  = (mem.rdata ^ DATA_W'(w_step[i])) == preamble;
        end
    end

    // Lowest survivor, survivor count and key of the selected candidate
    always_comb begin
        w_low = '0;
        w_cnt = '0;
        w_key = r_lfsr[0];
        for (int i = N_TAPS - 1; i >= 0; i--) begin
            if (r_mask[i]) w_low = 4'(i);
        end
        for (int i = 0; i < N_TAPS; i++) begin
            w_cnt = w_cnt + 5'(r_mask[i]);
            if (r_idx == 4'(i)) w_key = r_lfsr[i];
        end
    end

    // Next state and read address
    always_comb begin
        w_state_nxt = r_state;
        w_raddr     = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SEED;
                    w_raddr     = C_SRC;
                end
            end
            S_SEED: begin
                w_raddr     = w_k_addr;
                w_state_nxt = (r_p > cnt_t'(1)) ? S_TRAIN : S_RESOLVE;
            end
            S_TRAIN: begin
                w_raddr = w_k_addr;
                if (r_k == r_p - cnt_t'(1)) w_state_nxt = S_RESOLVE;
            end
            S_RESOLVE: begin
                w_raddr     = C_SRC;
                w_state_nxt = S_DECRYPT;
            end
            S_DECRYPT: begin
                w_raddr = w_k_addr;
                if (r_k == C_LEN - cnt_t'(1)) w_state_nxt = S_FIN;
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Char index, candidate LFSRs, survivor mask, write pointer and results
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_k     <= '0;
            r_p     <= cnt_t'(1);
            r_keep  <= 1'b0;
            r_mask  <= '1;
            r_seed  <= '0;
            r_waddr <= '0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_amb   <= 1'b0;
            r_idx   <= '0;
            for (int i = 0; i < N_TAPS; i++) r_lfsr[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_done  <= 1'b0;
                        r_error <= 1'b0;
                        r_amb   <= 1'b0;
                        r_mask  <= '1;
                        r_p     <= w_p;
                        r_keep  <= keep_pre;
                        r_k     <= '0;
                        r_waddr <= C_DST;
                    end
                end
                S_SEED: begin
                    r_seed <= w_seed;
                    for (int i = 0; i < N_TAPS; i++) r_lfsr[i] <= w_seed;
                    r_k <= r_k + cnt_t'(1);
                end
                S_TRAIN: begin
                    for (int i = 0; i < N_TAPS; i++) begin
                        r_lfsr[i] <= w_step[i];
                        if (!w_hit[i]) r_mask[i] <= 1'b0;
                    end
                    r_k <= r_k + cnt_t'(1);
                end
                S_RESOLVE: begin
                    r_idx   <= w_low;
                    r_error <= (r_mask == '0);
                    r_amb   <= (w_cnt > 5'd1);
                    for (int i = 0; i < N_TAPS; i++) r_lfsr[i] <= r_seed;
                    r_k <= '0;
                end
                S_DECRYPT: begin
                    for (int i = 0; i < N_TAPS; i++) r_lfsr[i] <= w_step[i];
                    r_k <= r_k + cnt_t'(1);
                    if (w_wr) r_waddr <= r_waddr + ADDR_W'(1);
                    if (r_k == C_LEN - cnt_t'(1)) r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lfsr_decrypter_multi.sv
// Bench for lfsr_decrypter_multi: table vectors, tap sweep, random runs
// and a reset-abort sequence, all against an array-based reference model.
module tb_lfsr_decrypter_multi;
    localparam int DST_BASE = 64;
    localparam int MSG_LEN  = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       keep_pre = 1'b0;
    logic [7:0] preamble = 8'h7E;
    logic [7:0] pre_len = 8'd6;
    logic       busy, done, error, ambiguous;
    logic [3:0] found_idx;

    lfsr_decrypter_multi_if #(.DATA_W(8), .ADDR_W(8)) bus ();

    lfsr_decrypter_multi dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .preamble(preamble), .pre_len(pre_len), .keep_pre(keep_pre),
        .busy(busy), .done(done), .error(error), .ambiguous(ambiguous),
        .found_idx(found_idx), .mem(bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    logic [7:0] wr_addr_q [$];
    logic [7:0] wr_data_q [$];

    // Data memory with one-cycle read latency; writes are logged in order
    always @(posedge clk) begin
        bus.rdata <= mem[bus.raddr];
        if (bus.wr_en) begin
            wr_addr_q.push_back(bus.waddr);
            wr_data_q.push_back(bus.wdata);
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    logic [4:0] TAPS [6];
    logic [7:0] pt [MSG_LEN];
    logic [7:0] ct [MSG_LEN];
    string      msg = "Hello, this is the multi-tap LFSR decrypter speaking.";

    int         m_idx, m_P;
    logic       m_err, m_amb;
    logic [5:0] m_mask;
    int         e_k [$];
    logic [7:0] e_d [$];

    function automatic logic [4:0] step(input logic [4:0] s, input logic [4:0] t);
        return {s[3:0], ^(s & t)};
    endfunction

    // Keystream for a tap/seed: element k keys character k
    function automatic void keystream(input logic [4:0] t, input logic [4:0] seed,
                                      output logic [4:0] ks [MSG_LEN]);
        ks[0] = seed;
        for (int k = 1; k < MSG_LEN; k++) ks[k] = step(ks[k-1], t);
    endfunction

    task automatic encrypt(input int tap, input logic [4:0] seed,
                           input logic corrupt, input logic rnd_body);
        logic [4:0] ks [MSG_LEN];
        keystream(TAPS[tap], seed, ks);
        for (int k = 0; k < MSG_LEN; k++) begin
            if (k < 6) pt[k] = 8'h7E;
            else if (rnd_body) pt[k] = 8'($urandom_range(32, 126));
            else if (k - 6 < msg.len()) pt[k] = msg[k-6];
            else pt[k] = 8'h2E;
            ct[k] = pt[k] ^ {3'b000, ks[k]};
            mem[k] = ct[k];
        end
        if (corrupt) begin
            ct[3] = ct[3] ^ 8'h80;
            mem[3] = ct[3];
        end
    endtask

    // Reference: survivors by full keystream comparison, then expected writes
    task automatic model(input int plen, input logic keep);
        logic [4:0] seed;
        logic [4:0] ks [MSG_LEN];
        logic [4:0] pre5;
        pre5 = preamble[4:0];
        m_P = (plen < 1) ? 1 : ((plen > MSG_LEN) ? MSG_LEN : plen);
        seed = ct[0][4:0] ^ pre5;
        m_mask = '0;
        for (int i = 0; i < 6; i++) begin
            keystream(TAPS[i], seed, ks);
            m_mask[i] = 1'b1;
            for (int k = 1; k < m_P; k++)
                if ((ct[k] ^ {3'b000, ks[k]}) != preamble) m_mask[i] = 1'b0;
        end
        m_idx = 0;
        for (int i = 5; i >= 0; i--) if (m_mask[i]) m_idx = i;
        m_err = (m_mask == '0);
        m_amb = ($countones(m_mask) > 1);
        keystream(TAPS[m_idx], seed, ks);
        e_k.delete();
        e_d.delete();
        for (int k = 0; k < MSG_LEN; k++) begin
            if (keep || k >= m_P) begin
                e_k.push_back(k);
                e_d.push_back(ct[k] ^ {3'b000, ks[k]});
            end
        end
    endtask

    task automatic check_writes(input int q0, input logic plain, input string tag);
        int n_got;
        n_got = wr_addr_q.size() - q0;
        check($sformatf("%s_nwr", tag), n_got, e_k.size());
        for (int n = 0; n < e_k.size() && n < n_got; n++) begin
            check($sformatf("%s_waddr%0d", tag, n), wr_addr_q[q0+n], 8'(DST_BASE + n));
            check($sformatf("%s_wdata%0d", tag, n), wr_data_q[q0+n],
                  plain ? pt[e_k[n]] : e_d[n]);
        end
    endtask

    task automatic wait_done(input string tag);
        int cyc = 0;
        while (!done && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check($sformatf("%s_done", tag), done, 1);
        check($sformatf("%s_busy_end", tag), busy, 0);
    endtask

    task automatic do_run(input string tag, input logic [7:0] plen,
                          input logic keep, input logic plain);
        int q0;
        @(negedge clk);
        pre_len = plen;
        keep_pre = keep;
        start = 1'b1;
        q0 = wr_addr_q.size();
        @(negedge clk);
        start = 1'b0;
        check($sformatf("%s_busy", tag), busy, 1);
        check($sformatf("%s_done_clr", tag), done, 0);
        wait_done(tag);
        check($sformatf("%s_err", tag), error, m_err);
        check($sformatf("%s_amb", tag), ambiguous, m_amb);
        check($sformatf("%s_idx", tag), found_idx, m_idx);
        check_writes(q0, plain, tag);
    endtask

    typedef struct {
        int         tap;
        logic [4:0] seed;
        logic [7:0] plen;
        logic       keep;
        logic       corrupt;
        logic [3:0] e_idx;
        logic       e_err;
        logic       e_amb;
        int         e_nwr;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int q0, cyc, tries;
        logic [4:0] seed;
        TAPS = '{5'h1E, 5'h1D, 5'h1B, 5'h17, 5'h14, 5'h12};
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;

        tbl[0] = '{0, 5'h1E, 8'd6,   1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 58};
        tbl[1] = '{3, 5'h1E, 8'd6,   1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 64};
        tbl[2] = '{0, 5'h1E, 8'd1,   1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 63};
        tbl[3] = '{0, 5'h1E, 8'd6,   1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 58};
        tbl[4] = '{0, 5'h1E, 8'd0,   1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 64};
        tbl[5] = '{0, 5'h1E, 8'd200, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 0};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_amb", ambiguous, 0);
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_idx", found_idx, 0);
        check("rst_raddr", bus.raddr, 0);
        check("rst_waddr", bus.waddr, 0);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            encrypt(tbl[v].tap, tbl[v].seed, tbl[v].corrupt, 1'b0);
            model(int'(tbl[v].plen), tbl[v].keep);
            do_run($sformatf("vec%0d", v), tbl[v].plen, tbl[v].keep, !tbl[v].e_err);
            check($sformatf("vec%0d_tidx", v), found_idx, tbl[v].e_idx);
            check($sformatf("vec%0d_terr", v), error, tbl[v].e_err);
            check($sformatf("vec%0d_tamb", v), ambiguous, tbl[v].e_amb);
            check($sformatf("vec%0d_tnwr", v), e_k.size(), tbl[v].e_nwr);
            if (v == 0) begin
                repeat (3) @(negedge clk);
                check("done_level", done, 1);
            end
        end

        for (int t = 1; t < 6; t++) begin
            tries = 0;
            do begin
                seed = 5'($urandom_range(1, 31));
                encrypt(t, seed, 1'b0, 1'b1);
                model(6, 1'b0);
                tries++;
            end while (m_mask != 6'(1 << t) && tries < 200);
            do_run($sformatf("tap%0d", t), 8'd6, 1'b0, 1'b1);
            check($sformatf("tap%0d_used", t), found_idx, t);
        end

        for (int r = 0; r < 8; r++) begin
            int   tap, plen;
            logic keep, corrupt;
            tap = $urandom_range(0, 5);
            seed = 5'($urandom_range(0, 31));
            plen = ($urandom_range(0, 4) == 0) ? $urandom_range(60, 255)
                                               : $urandom_range(0, 12);
            keep = 1'($urandom_range(0, 1));
            corrupt = ($urandom_range(0, 3) == 0);
            encrypt(tap, seed, corrupt, 1'b1);
            model(plen, keep);
            do_run($sformatf("rnd%0d", r), 8'(plen), keep, 1'b0);
        end

        encrypt(0, 5'h1E, 1'b0, 1'b0);
        model(6, 1'b0);
        @(negedge clk);
        pre_len = 8'd6;
        keep_pre = 1'b0;
        start = 1'b1;
        q0 = wr_addr_q.size();
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(bus.wr_en && bus.waddr == 8'(DST_BASE + 14)) && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_reach_k20", bus.wr_en, 1);
        rst_n = 1'b0;
        #1;
        check("abort_wr_in_rst", bus.wr_en, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_wr_en", bus.wr_en, 0);
        check("abort_nwr", wr_addr_q.size() - q0, 14);
        repeat (5) @(negedge clk);
        check("abort_stray", wr_addr_q.size() - q0, 14);

        @(negedge clk);
        start = 1'b1;
        q0 = wr_addr_q.size();
        @(negedge clk);
        start = 1'b0;
        check("rerun_busy", busy, 1);
        repeat (3) @(negedge clk);
        pre_len = 8'd1;
        keep_pre = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_start_ign", busy, 1);
        wait_done("rerun");
        check("rerun_err", error, 0);
        check("rerun_amb", ambiguous, 0);
        check("rerun_idx", found_idx, 0);
        check_writes(q0, 1'b1, "rerun");
        repeat (3) @(negedge clk);
        check("rerun_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
